// File: rtl/io_mem_loader.sv
// Byte-stream loader/dumper for the IO port of the 16-bit unified memory.
// LOAD (0x01) writes words received over the byte link; DUMP (0x02) streams
// words back out. Header: OPC, ADDR_H, ADDR_L, CNT_H, CNT_L (big-endian).
module io_mem_loader #(
    parameter int unsigned MEM_SIZE     = 200,
    parameter bit          HOLD_ON_LOAD = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic [15:0] RADDR_IO,
    input  logic [15:0] DATA_OUT_IO,
    output logic [15:0] WADDR_IO,
    output logic [15:0] DATA_IN_IO,
    output logic        MW_IO_ON,
    output logic        BUSY,
    output logic        CPU_HOLD,
    output logic        DONE,
    output logic        ERR
);

    localparam logic [16:0] MemLimit = 17'(MEM_SIZE);

    typedef enum logic [2:0] {
        StIdle, StHdr, StLdHi, StLdLo, StWr, StDpRd, StDpHi, StDpLo
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic        is_load_q, is_load_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] word_q, word_d;
    logic [15:0] waddr_q, waddr_d;
    logic [15:0] din_q, din_d;
    logic [15:0] raddr_q, raddr_d;
    logic        mw_q, mw_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        rx_ready_q, rx_ready_d;

    logic        rx_fire;
    logic        tx_fire;
    logic        addr_ok;

    assign rx_fire = RX_VALID & rx_ready_q;
    assign tx_fire = TX_VALID & TX_READY;
    assign addr_ok = ({1'b0, addr_q} < MemLimit);

    // Next-state logic: command parsing, word assembly, write and dump sequencing.
    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        is_load_d = is_load_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        waddr_d   = waddr_q;
        din_d     = din_q;
        raddr_d   = raddr_q;
        mw_d      = 1'b0;
        err_d     = err_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    err_d = 1'b0;
                    if (RX_DATA == 8'h01 || RX_DATA == 8'h02) begin
                        is_load_d = (RX_DATA == 8'h01);
                        hdr_cnt_d = 2'd0;
                        state_d   = StHdr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StHdr: begin
                if (rx_fire) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    unique case (hdr_cnt_q)
                        2'd0: addr_d[15:8] = RX_DATA;
                        2'd1: addr_d[7:0]  = RX_DATA;
                        2'd2: cnt_d[15:8]  = RX_DATA;
                        2'd3: begin
                            cnt_d[7:0] = RX_DATA;
                            if ({cnt_q[15:8], RX_DATA} == 16'd0) begin
                                done_d  = 1'b1;
                                state_d = StIdle;
                            end else begin
                                state_d = is_load_q ? StLdHi : StDpRd;
                            end
                        end
                    endcase
                end
            end
            StLdHi: begin
                if (rx_fire) begin
                    word_d[15:8] = RX_DATA;
                    state_d      = StLdLo;
                end
            end
            StLdLo: begin
                if (rx_fire) begin
                    // Write strobe, address and data are registered on entry to
                    // StWr so they are steady across the memory's negedge capture.
                    word_d[7:0] = RX_DATA;
                    waddr_d     = addr_q;
                    din_d       = {word_q[15:8], RX_DATA};
                    mw_d        = addr_ok;
                    state_d     = StWr;
                end
            end
            StWr: begin
                if (!addr_ok) begin
                    err_d = 1'b1;
                end
                addr_d = addr_q + 16'd1;
                cnt_d  = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StLdHi;
                end
            end
            StDpRd: begin
                // RADDR_IO already points at addr_q; out-of-range reads return zero.
                word_d  = addr_ok ? DATA_OUT_IO : 16'h0000;
                if (!addr_ok) begin
                    err_d = 1'b1;
                end
                state_d = StDpHi;
            end
            StDpHi: begin
                if (tx_fire) begin
                    state_d = StDpLo;
                end
            end
            StDpLo: begin
                if (tx_fire) begin
                    addr_d = addr_q + 16'd1;
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StDpRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StDpRd) begin
            raddr_d = addr_d;
        end

        rx_ready_d = (state_d == StIdle) || (state_d == StHdr) ||
                     (state_d == StLdHi) || (state_d == StLdLo);
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            hdr_cnt_q  <= 2'd0;
            is_load_q  <= 1'b0;
            addr_q     <= 16'h0000;
            cnt_q      <= 16'h0000;
            word_q     <= 16'h0000;
            waddr_q    <= 16'h0000;
            din_q      <= 16'h0000;
            raddr_q    <= 16'h0000;
            mw_q       <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            is_load_q  <= is_load_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            din_q      <= din_d;
            raddr_q    <= raddr_d;
            mw_q       <= mw_d;
            err_q      <= err_d;
            done_q     <= done_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        TX_DATA = 8'h00;
        if (state_q == StDpHi) begin
            TX_DATA = word_q[15:8];
        end else if (state_q == StDpLo) begin
            TX_DATA = word_q[7:0];
        end
    end

    assign RX_READY   = rx_ready_q;
    assign TX_VALID   = (state_q == StDpHi) || (state_q == StDpLo);
    assign RADDR_IO   = raddr_q;
    assign WADDR_IO   = waddr_q;
    assign DATA_IN_IO = din_q;
    assign MW_IO_ON   = mw_q;
    assign BUSY       = (state_q != StIdle);
    assign CPU_HOLD   = HOLD_ON_LOAD && is_load_q &&
                        ((state_q == StHdr) || (state_q == StLdHi) ||
                         (state_q == StLdLo) || (state_q == StWr));
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_io_mem_loader.sv
// Bench for io_mem_loader: directed scenarios plus randomized LOAD/DUMP traffic,
// checked against a word-array reference memory kept by the bench.
module tb_io_mem_loader;

    localparam int unsigned MEM = 200;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        RX_READY;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b0;
    logic [15:0] RADDR_IO;
    logic [15:0] DATA_OUT_IO;
    logic [15:0] WADDR_IO;
    logic [15:0] DATA_IN_IO;
    logic        MW_IO_ON;
    logic        BUSY;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERR;

    io_mem_loader #(
        .MEM_SIZE     (MEM),
        .HOLD_ON_LOAD (1'b1)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_DATA     (RX_DATA),
        .RX_VALID    (RX_VALID),
        .RX_READY    (RX_READY),
        .TX_DATA     (TX_DATA),
        .TX_VALID    (TX_VALID),
        .TX_READY    (TX_READY),
        .RADDR_IO    (RADDR_IO),
        .DATA_OUT_IO (DATA_OUT_IO),
        .WADDR_IO    (WADDR_IO),
        .DATA_IN_IO  (DATA_IN_IO),
        .MW_IO_ON    (MW_IO_ON),
        .BUSY        (BUSY),
        .CPU_HOLD    (CPU_HOLD),
        .DONE        (DONE),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    logic [15:0] ld_words [0:15];

    function automatic bit in_range(input logic [15:0] a);
        return a < 16'(MEM);
    endfunction

    // Attached memory: combinational read, garbage outside the populated range.
    assign DATA_OUT_IO = in_range(RADDR_IO) ? mem[RADDR_IO[7:0]] : 16'hDEAD;

    int   mw_cnt = 0;
    int   mw_bad = 0;
    int   done_cnt = 0;
    int   hold_bad = 0;
    bit   cur_is_load = 1'b0;
    logic mw_prev = 1'b0;

    // Memory write port plus protocol monitors, sampled mid-cycle.
    always @(negedge CLK) begin
        if (MW_IO_ON === 1'b1) begin
            mw_cnt <= mw_cnt + 1;
            if (!in_range(WADDR_IO) || mw_prev) mw_bad <= mw_bad + 1;
            mem[WADDR_IO[7:0]] <= DATA_IN_IO;
        end
        mw_prev <= MW_IO_ON;
        if (DONE === 1'b1) done_cnt <= done_cnt + 1;
        if (BUSY === 1'b1 ? (CPU_HOLD !== cur_is_load) : (CPU_HOLD !== 1'b0))
            hold_bad <= hold_bad + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {1'b0, RX_READY, TX_VALID, TX_DATA, MW_IO_ON, RADDR_IO, WADDR_IO, DATA_IN_IO,
                BUSY, CPU_HOLD, DONE, ERR};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        while (RX_READY !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("rx_ready", RX_READY, 1);
        @(posedge CLK);
        #1;
        RX_VALID = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [15:0] addr, input logic [15:0] cnt);
        send_byte(op);
        check("opc_err", ERR, 0);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(cnt[15:8]);
        send_byte(cnt[7:0]);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (DONE !== 1'b1 && n < 400);
        check("done_seen", DONE, 1);
    endtask

    task automatic run_load(input logic [15:0] addr, input int cnt);
        int n, m0, d0, nin;
        bit exp_err;
        logic [15:0] a;
        m0 = mw_cnt;
        d0 = done_cnt;
        nin = 0;
        exp_err = 1'b0;
        cur_is_load = 1'b1;
        send_hdr(8'h01, addr, 16'(cnt));
        for (int i = 0; i < cnt; i++) begin
            send_byte(ld_words[i][15:8]);
            send_byte(ld_words[i][7:0]);
            a = addr + 16'(i);
            if (in_range(a)) begin
                ref_mem[a[7:0]] = ld_words[i];
                nin++;
            end else begin
                exp_err = 1'b1;
            end
        end
        wait_done(n);
        check("load_latency", n, (cnt > 0) ? 2 : 1);
        @(posedge CLK);
        #1;
        check("load_writes", mw_cnt - m0, nin);
        check("load_done_once", done_cnt - d0, 1);
        check("load_err", ERR, exp_err);
        check("load_busy", BUSY, 0);
    endtask

    task automatic run_dump(input logic [15:0] addr, input int cnt, input int stall, input bit tied);
        logic [7:0]  got[$];
        int          n, st, tx_bad, d0;
        logic        pv, pr;
        logic [7:0]  pd;
        bit          exp_err;
        logic [15:0] a, w;
        logic [31:0] obs;
        d0 = done_cnt;
        cur_is_load = 1'b0;
        TX_READY = tied;
        send_hdr(8'h02, addr, 16'(cnt));
        n = 0;
        st = stall;
        tx_bad = 0;
        pv = 1'b0;
        pr = 1'b0;
        pd = 8'h00;
        do begin
            @(negedge CLK);
            n++;
            if (pv && !pr && (TX_VALID !== 1'b1 || TX_DATA !== pd)) tx_bad++;
            if (DONE !== 1'b1) begin
                if (tied) TX_READY = 1'b1;
                else if (st > 0) begin
                    TX_READY = 1'b0;
                    if (TX_VALID === 1'b1) st--;
                end else TX_READY = 1'($urandom_range(0, 1));
                if (TX_VALID === 1'b1 && TX_READY) got.push_back(TX_DATA);
                pv = TX_VALID;
                pr = TX_READY;
                pd = TX_DATA;
            end
        end while (DONE !== 1'b1 && n < 2000);
        check("dump_done", DONE, 1);
        if (tied) check("dump_latency", n, 3 * cnt + 1);
        check("dump_len", got.size(), 2 * cnt);
        exp_err = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            a = addr + 16'(i);
            w = in_range(a) ? ref_mem[a[7:0]] : 16'h0000;
            if (!in_range(a)) exp_err = 1'b1;
            obs = (2 * i + 1 < got.size()) ? {16'h0000, got[2*i], got[2*i+1]} : 32'hFFFF_FFFF;
            check("dump_word", obs, w);
        end
        check("dump_tx_stable", tx_bad, 0);
        @(posedge CLK);
        #1;
        TX_READY = 1'b0;
        check("dump_err", ERR, exp_err);
        check("dump_busy", BUSY, 0);
        check("dump_done_once", done_cnt - d0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v, a, w0;
        int n, d0, m0, cnt, r;

        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        #2 RST = 1'b1;
        #1 check("reset_async", all_outs(), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1 check("reset_release", all_outs(), 0);
        @(posedge CLK);
        #1 check("rx_ready_after_reset", RX_READY, 1);

        // LOAD two words at 0x0010
        ld_words[0] = 16'hC011;
        ld_words[1] = 16'hC122;
        run_load(16'h0010, 2);
        check("mem16", mem[16], 16'hC011);
        check("mem17", mem[17], 16'hC122);
        check("hold_directed", hold_bad, 0);

        // DUMP with 5 cycles of backpressure
        mem[4] <= 16'h7410;
        ref_mem[4] = 16'h7410;
        run_dump(16'h0004, 1, 5, 1'b0);

        // LOAD straddling the end of memory
        ld_words[0] = 16'($urandom);
        ld_words[1] = 16'($urandom);
        run_load(16'h00C7, 2);
        check("mem199", mem[199], ld_words[0]);
        repeat (3) @(negedge CLK);
        check("err_sticky", ERR, 1);

        // Bad opcode, then a zero-count LOAD
        send_byte(8'h55);
        check("bad_opc_err", ERR, 1);
        check("bad_opc_idle", BUSY, 0);
        m0 = mw_cnt;
        run_load(16'h0000, 0);
        check("cnt0_no_write", mw_cnt - m0, 0);

        // Reset in the middle of the second word of a 3-word LOAD
        a = 16'(40 + $urandom_range(0, 20));
        w0 = 16'($urandom);
        d0 = done_cnt;
        cur_is_load = 1'b1;
        send_hdr(8'h01, a, 16'd3);
        send_byte(w0[15:8]);
        send_byte(w0[7:0]);
        ref_mem[a[7:0]] = w0;
        send_byte(8'hA5);
        #2 RST = 1'b1;
        #1 check("abort_outs", all_outs(), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1 check("abort_rx_ready_low", RX_READY, 0);
        @(posedge CLK);
        #1 check("abort_rx_ready", RX_READY, 1);
        check("abort_w0", mem[a[7:0]], w0);
        check("abort_w1", mem[a[7:0] + 8'd1], ref_mem[a[7:0] + 8'd1]);
        check("abort_no_done", done_cnt - d0, 0);
        run_dump(a, 3, 0, 1'b1);

        // Randomized traffic
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 7);
            if (r < 6) a = 16'($urandom_range(0, MEM - 8));
            else if (r == 6) a = 16'(MEM - 3 + $urandom_range(0, 2));
            else a = 16'hFFFE;
            cnt = $urandom_range(1, 5);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < cnt; i++) ld_words[i] = 16'($urandom);
                run_load(a, cnt);
            end else begin
                run_dump(a, cnt, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        @(negedge CLK);
        n = 0;
        for (int i = 0; i < int'(MEM); i++) if (mem[i] !== ref_mem[i]) n++;
        check("mem_final", n, 0);
        check("mw_protocol", mw_bad, 0);
        check("cpu_hold", hold_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
